// File: rtl/pipe_ctrl_pkg.sv
// Shared pipeline-control definitions: stall vector layout and canned stall masks.
package pipe_ctrl_pkg;

   localparam int STALL_PC    = 0;
   localparam int STALL_IF    = 1;
   localparam int STALL_ID    = 2;
   localparam int STALL_EX    = 3;
   localparam int STALL_WIDTH = 4;

   localparam logic [STALL_WIDTH-1:0] STALL_ALL = '1;

   // Load-use: freeze the front end and let a bubble fall into EX.
   function automatic logic [STALL_WIDTH-1:0] ld_use_mask();
      logic [STALL_WIDTH-1:0] m;
      m           = '0;
      m[STALL_PC] = 1'b1;
      m[STALL_IF] = 1'b1;
      m[STALL_ID] = 1'b1;
      return m;
   endfunction

endpackage

// File: rtl/pipe_ctrl_if.sv
// Hazard/redirect request bundle into the pipeline controller and its stall/flush outputs.
interface pipe_ctrl_if
   import pipe_ctrl_pkg::*;
#(
   parameter int CNT_W = 32
);
   logic                   ex_busy_i;
   logic                   ld_use_i;
   logic                   jump_i;
   logic [31:0]            jump_addr_i;
   logic                   int_req_i;
   logic [31:0]            int_addr_i;
   logic                   halt_req_i;
   logic                   cnt_clr_i;
   logic [STALL_WIDTH-1:0] stall_o;
   logic                   flush_o;
   logic [31:0]            flush_addr_o;
   logic                   int_ack_o;
   logic                   halted_o;
   logic [CNT_W-1:0]       stall_cnt_o;

   modport master (
      output ex_busy_i, ld_use_i, jump_i, jump_addr_i, int_req_i, int_addr_i,
             halt_req_i, cnt_clr_i,
      input  stall_o, flush_o, flush_addr_o, int_ack_o, halted_o, stall_cnt_o
   );

   modport slave (
      input  ex_busy_i, ld_use_i, jump_i, jump_addr_i, int_req_i, int_addr_i,
             halt_req_i, cnt_clr_i,
      output stall_o, flush_o, flush_addr_o, int_ack_o, halted_o, stall_cnt_o
   );
endinterface

// File: rtl/pipe_stall_cnt.sv
// Saturating stall-cycle counter; clear beats increment.
module pipe_stall_cnt #(
   parameter int CNT_W = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             inc_i,
   input  logic             clr_i,
   output logic [CNT_W-1:0] cnt_o
);
   logic [CNT_W-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (clr_i)
         cnt_d = '0;
      else if (inc_i && !(&cnt_q))
         cnt_d = cnt_q + CNT_W'(1);
   end

   always_ff @(posedge clk) begin
      if (rst) cnt_q <= '0;
      else     cnt_q <= cnt_d;
   end

   assign cnt_o = cnt_q;
endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline controller: stall vector, flush strobe/target, interrupt accept and debug halt.
module pipe_ctrl
   import pipe_ctrl_pkg::*;
#(
   parameter int FLUSH_CYCLES = 1,
   parameter int CNT_W        = 32
) (
   input logic        clk,
   input logic        rst,
   pipe_ctrl_if.slave bus
);
   localparam int FC_W = (FLUSH_CYCLES > 2) ? $clog2(FLUSH_CYCLES - 1) : 1;
   localparam logic [FC_W-1:0] FC_LOAD = FC_W'((FLUSH_CYCLES > 1) ? FLUSH_CYCLES - 2 : 0);

   typedef enum logic [1:0] {ST_RUN, ST_FLUSH, ST_HALT} state_e;

   state_e           state_q, state_d;
   logic [FC_W-1:0]  fcnt_q, fcnt_d;
   logic [31:0]      tgt_q, tgt_d;

   logic [STALL_WIDTH-1:0] stall;
   logic                   flush, ack, halted;
   logic [31:0]            faddr;
   logic [CNT_W-1:0]       cnt;

   // All outputs stay at their defaults (0) while rst is high.
   always_comb begin
      state_d = state_q;
      fcnt_d  = fcnt_q;
      tgt_d   = tgt_q;
      stall   = '0;
      flush   = 1'b0;
      faddr   = '0;
      ack     = 1'b0;
      halted  = 1'b0;
      if (!rst) begin
         unique case (state_q)
            ST_RUN: begin
               if (bus.ex_busy_i) begin
                  stall = STALL_ALL;
               end else if (bus.jump_i) begin
                  flush = 1'b1;
                  faddr = bus.jump_addr_i;
                  tgt_d = bus.jump_addr_i;
                  if (FLUSH_CYCLES > 1) begin
                     state_d = ST_FLUSH;
                     fcnt_d  = FC_LOAD;
                  end
               end else if (bus.int_req_i) begin
                  flush = 1'b1;
                  ack   = 1'b1;
                  faddr = bus.int_addr_i;
                  tgt_d = bus.int_addr_i;
                  if (FLUSH_CYCLES > 1) begin
                     state_d = ST_FLUSH;
                     fcnt_d  = FC_LOAD;
                  end
               end else if (bus.halt_req_i) begin
                  stall   = STALL_ALL;
                  halted  = 1'b1;
                  state_d = ST_HALT;
               end else if (bus.ld_use_i) begin
                  stall = ld_use_mask();
               end
            end
            ST_FLUSH: begin
               flush = 1'b1;
               faddr = tgt_q;
               if (fcnt_q == '0) state_d = ST_RUN;
               else              fcnt_d  = fcnt_q - FC_W'(1);
            end
            ST_HALT: begin
               stall  = STALL_ALL;
               halted = 1'b1;
               if (!bus.halt_req_i) state_d = ST_RUN;
            end
            default: state_d = ST_RUN;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_RUN;
         fcnt_q  <= '0;
         tgt_q   <= '0;
      end else begin
         state_q <= state_d;
         fcnt_q  <= fcnt_d;
         tgt_q   <= tgt_d;
      end
   end

   pipe_stall_cnt #(.CNT_W(CNT_W)) u_stall_cnt (
      .clk   (clk),
      .rst   (rst),
      .inc_i (stall[STALL_PC]),
      .clr_i (bus.cnt_clr_i),
      .cnt_o (cnt)
   );

   assign bus.stall_o      = stall;
   assign bus.flush_o      = flush;
   assign bus.flush_addr_o = faddr;
   assign bus.int_ack_o    = ack;
   assign bus.halted_o     = halted;
   assign bus.stall_cnt_o  = rst ? '0 : cnt;
endmodule

// File: tb/tb_pipe_ctrl.sv
// Scoreboard bench for pipe_ctrl: two instances (FLUSH_CYCLES=1/CNT_W=32, FLUSH_CYCLES=3/CNT_W=4).
module tb_pipe_ctrl;
   import pipe_ctrl_pkg::*;

   typedef struct {
      logic [3:0]  stall;
      logic        flush;
      logic [31:0] addr;
      logic        ack;
      logic        halted;
      logic [31:0] cnt;
   } exp_t;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst = 1'b1;
   logic        busy = 1'b0, ld = 1'b0, jmp = 1'b0, halt = 1'b0, clr = 1'b0;
   logic [31:0] jaddr = '0;
   logic        ireq [2];
   logic [31:0] iaddr [2];

   pipe_ctrl_if #(.CNT_W(32)) if_a ();
   pipe_ctrl_if #(.CNT_W(4))  if_b ();

   assign if_a.ex_busy_i = busy;  assign if_b.ex_busy_i = busy;
   assign if_a.ld_use_i  = ld;    assign if_b.ld_use_i  = ld;
   assign if_a.jump_i    = jmp;   assign if_b.jump_i    = jmp;
   assign if_a.jump_addr_i = jaddr; assign if_b.jump_addr_i = jaddr;
   assign if_a.halt_req_i = halt; assign if_b.halt_req_i = halt;
   assign if_a.cnt_clr_i = clr;   assign if_b.cnt_clr_i = clr;
   assign if_a.int_req_i = ireq[0]; assign if_a.int_addr_i = iaddr[0];
   assign if_b.int_req_i = ireq[1]; assign if_b.int_addr_i = iaddr[1];

   pipe_ctrl #(.FLUSH_CYCLES(1), .CNT_W(32)) u_a (.clk(clk), .rst(rst), .bus(if_a));
   pipe_ctrl #(.FLUSH_CYCLES(3), .CNT_W(4))  u_b (.clk(clk), .rst(rst), .bus(if_b));

   // Reference model state: remaining flush cycles, halted flag, target, counter.
   int          fc        [2] = '{1, 3};
   longint      cmax      [2] = '{64'hFFFF_FFFF, 64'hF};
   int          flush_left[2] = '{0, 0};
   bit          halted_m  [2] = '{0, 0};
   logic [31:0] tgt_m     [2];
   longint      cnt_m     [2] = '{0, 0};
   bit          int_pend  [2] = '{0, 0};

   exp_t q0[$], q1[$];
   int n_cmp = 0, n_err = 0;
   int cyc = 0;

   task automatic model(input int k, input bit r, input bit c, output exp_t e);
      e.stall = '0; e.flush = 0; e.addr = '0; e.ack = 0; e.halted = 0;
      e.cnt = r ? 32'd0 : cnt_m[k][31:0];
      if (r) begin
         flush_left[k] = 0; halted_m[k] = 0; tgt_m[k] = '0; cnt_m[k] = 0;
         return;
      end
      if (flush_left[k] > 0) begin
         e.flush = 1; e.addr = tgt_m[k]; flush_left[k]--;
      end else if (halted_m[k]) begin
         e.stall = 4'hF; e.halted = 1;
         if (!halt) halted_m[k] = 0;
      end else if (busy) begin
         e.stall = 4'hF;
      end else if (jmp) begin
         e.flush = 1; e.addr = jaddr; tgt_m[k] = jaddr; flush_left[k] = fc[k] - 1;
      end else if (ireq[k]) begin
         e.flush = 1; e.addr = iaddr[k]; e.ack = 1; tgt_m[k] = iaddr[k];
         flush_left[k] = fc[k] - 1; int_pend[k] = 0;
      end else if (halt) begin
         e.stall = 4'hF; e.halted = 1; halted_m[k] = 1;
      end else if (ld) begin
         e.stall = 4'b0111;
      end
      if (c) cnt_m[k] = 0;
      else if (e.stall[STALL_PC] && cnt_m[k] < cmax[k]) cnt_m[k]++;
   endtask

   task automatic step(input bit r, input bit b, input bit l, input bit j, input logic [31:0] ja,
                       input bit ri, input logic [31:0] ia, input bit h, input bit c);
      exp_t e;
      @(posedge clk); #1;
      cyc++;
      rst = r; busy = b; ld = l; jmp = j; jaddr = ja; halt = h; clr = c;
      for (int k = 0; k < 2; k++) begin
         if (!int_pend[k] && ri) begin int_pend[k] = 1; iaddr[k] = ia; end
         ireq[k] = int_pend[k];
      end
      model(0, r, c, e); q0.push_back(e);
      model(1, r, c, e); q1.push_back(e);
   endtask

   task automatic chk(input string nm, input int k, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s inst%0d cyc%0d: got %h expected %h", nm, k, cyc, act, exp);
      end
   endtask

   // Monitor: every cycle the DUTs present outputs; pop and compare.
   always @(negedge clk) begin
      exp_t e;
      if (q0.size() > 0) begin
         e = q0.pop_front();
         chk("stall", 0, 32'(if_a.stall_o), 32'(e.stall));
         chk("flush", 0, 32'(if_a.flush_o), 32'(e.flush));
         chk("flush_addr", 0, if_a.flush_addr_o, e.addr);
         chk("int_ack", 0, 32'(if_a.int_ack_o), 32'(e.ack));
         chk("halted", 0, 32'(if_a.halted_o), 32'(e.halted));
         chk("stall_cnt", 0, if_a.stall_cnt_o, e.cnt);
      end
      if (q1.size() > 0) begin
         e = q1.pop_front();
         chk("stall", 1, 32'(if_b.stall_o), 32'(e.stall));
         chk("flush", 1, 32'(if_b.flush_o), 32'(e.flush));
         chk("flush_addr", 1, if_b.flush_addr_o, e.addr);
         chk("int_ack", 1, 32'(if_b.int_ack_o), 32'(e.ack));
         chk("halted", 1, 32'(if_b.halted_o), 32'(e.halted));
         chk("stall_cnt", 1, 32'(if_b.stall_cnt_o), e.cnt);
      end
   end

   initial begin
      bit h = 0;
      ireq[0] = 0; ireq[1] = 0; iaddr[0] = '0; iaddr[1] = '0;
      // directed scenarios
      step(1,0,0,0,0,0,0,0,0); step(1,0,0,0,0,0,0,0,0);
      step(0,0,0,0,0,0,0,0,0); step(0,0,0,0,0,0,0,0,0);
      step(0,0,1,0,0,0,0,0,0); step(0,0,0,0,0,0,0,0,0);
      step(0,0,0,1,32'h100,0,0,0,0);
      for (int i = 0; i < 3; i++) step(0,0,0,0,0,0,0,0,0);
      step(0,0,0,1,32'h200,0,0,0,0); step(0,0,0,1,32'h300,0,0,0,0);
      for (int i = 0; i < 3; i++) step(0,0,0,0,0,0,0,0,0);
      for (int i = 0; i < 4; i++) step(0,1,0,0,0,1,32'h80,0,0);
      for (int i = 0; i < 4; i++) step(0,0,0,0,0,0,0,0,0);
      step(0,0,0,1,32'h400,1,32'h90,0,0);
      for (int i = 0; i < 5; i++) step(0,0,0,0,0,0,0,0,0);
      for (int i = 0; i < 3; i++) step(0,0,0,0,0,0,0,1,0);
      step(1,0,0,0,0,0,0,1,0); step(0,0,0,0,0,0,0,1,0);
      step(0,0,0,0,0,0,0,0,0); step(0,0,0,0,0,0,0,0,0);
      // randomized traffic
      for (int i = 0; i < 3000; i++) begin
         if (h) h = ($urandom_range(99) < 80);
         else   h = ($urandom_range(99) < 5);
         step($urandom_range(99) < 2, $urandom_range(99) < 20, $urandom_range(99) < 20,
              $urandom_range(99) < 15, $urandom & ~32'h3,
              $urandom_range(99) < 10, $urandom & ~32'h3, h, $urandom_range(99) < 1);
      end
      @(negedge clk); @(negedge clk);
      chk("queue_drained", 0, 32'(q0.size() + q1.size()), 32'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
